perlin_noise_pipe: RTL and testbench

Pipelined 2D gradient-noise generator that sits between the VGA sync generator and the colour output stage of the Perlin demo. Each cycle it accepts a pixel coordinate plus the sync/active sideband and returns an 8-bit noise value four cycles later, with the sideband delayed to match. A per-frame time offset scrolls the field horizontally for animation.

---
 rtl/perlin_noise_pipe.sv | 208 ++++++++++++++++++++
 tb/tb_perlin_noise_pipe.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/perlin_noise_pipe.sv
// Pipelined 2D gradient-noise generator: pixel coordinate in, 8-bit noise out four cycles later,
// with the sync/active sideband delayed to match and a per-frame horizontal scroll offset.
module perlin_noise_pipe #(
    parameter int unsigned CELL_LOG2 = 5,
    parameter logic [7:0]  SEED      = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       in_valid,
    input  logic [2:0] side_in,
    input  logic       frame_start,
    output logic [7:0] noise,
    output logic       out_valid,
    output logic [2:0] side_out
);

    localparam int unsigned CW = 10;  // coordinate width
    localparam int unsigned FW = 8;   // fraction / fade / hash width
    localparam int unsigned DW = 11;  // corner dot-product width
    localparam int unsigned LW = 12;  // lerp result width

    // Gradient index of lattice corner (i, j).
    function automatic logic [1:0] grad_sel(input logic [FW-1:0] i, input logic [FW-1:0] j);
        return 2'((16'(i) * 16'd37 + 16'(j) * 16'd113) ^ 16'(SEED));
    endfunction

    // g[0] negates the x term, g[1] negates the y term.
    function automatic logic signed [DW-1:0] dot(input logic [1:0] g,
                                                 input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
        logic signed [DW-1:0] ta;
        logic signed [DW-1:0] tb;
        ta = g[0] ? -a : a;
        tb = g[1] ? -b : b;
        return ta + tb;
    endfunction

    function automatic logic [FW-1:0] fade(input logic [FW-1:0] w);
        logic [23:0] sq;
        logic [23:0] k;
        sq = 24'(w) * 24'(w);
        k  = 24'd768 - (24'(w) << 1);
        return 8'((sq * k) >> 16);
    endfunction

    // Floor-rounded linear interpolation; result always lies between a and b.
    function automatic logic signed [LW-1:0] lerp(input logic signed [LW-1:0] a,
                                                  input logic signed [LW-1:0] b,
                                                  input logic [FW-1:0] s);
        logic signed [12:0] diff;
        logic signed [21:0] prod;
        diff = 13'(b) - 13'(a);
        prod = 22'(diff) * $signed(22'({1'b0, s}));
        return a + 12'(prod >>> 8);
    endfunction

    logic [FW-1:0] t_q, t_d;

    logic          s1_valid_q, s1_valid_d;
    logic [2:0]    s1_side_q, s1_side_d;
    logic [FW-1:0] s1_u_q, s1_u_d, s1_v_q, s1_v_d;
    logic [1:0]    s1_g00_q, s1_g00_d, s1_g10_q, s1_g10_d;
    logic [1:0]    s1_g01_q, s1_g01_d, s1_g11_q, s1_g11_d;

    logic                 s2_valid_q, s2_valid_d;
    logic [2:0]           s2_side_q, s2_side_d;
    logic signed [DW-1:0] s2_d00_q, s2_d00_d, s2_d10_q, s2_d10_d;
    logic signed [DW-1:0] s2_d01_q, s2_d01_d, s2_d11_q, s2_d11_d;
    logic [FW-1:0]        s2_su_q, s2_su_d, s2_sv_q, s2_sv_d;

    logic                 s3_valid_q, s3_valid_d;
    logic [2:0]           s3_side_q, s3_side_d;
    logic signed [LW-1:0] s3_nx0_q, s3_nx0_d, s3_nx1_q, s3_nx1_d;
    logic [FW-1:0]        s3_sv_q, s3_sv_d;

    logic          out_valid_q, out_valid_d;
    logic [2:0]    side_out_q, side_out_d;
    logic [FW-1:0] noise_q, noise_d;

    logic [CW-1:0] xe;
    logic [FW-1:0] ci, cj, ci1, cj1;
    logic signed [DW-1:0] uo, um, vo, vm;
    logic signed [LW-1:0] n;
    logic signed [LW-1:0] nq;
    logic signed [12:0]   nsum;

    // S1: scrolled coordinate, cell, fractions and corner gradients.
    always_comb begin
        t_d        = frame_start ? t_q + 8'd1 : t_q;
        xe         = x + 10'(t_q);
        ci         = 8'(xe >> CELL_LOG2);
        cj         = 8'(y >> CELL_LOG2);
        ci1        = ci + 8'd1;
        cj1        = cj + 8'd1;
        s1_valid_d = in_valid;
        s1_side_d  = side_in;
        s1_u_d     = 8'(16'(xe[CELL_LOG2-1:0]) << (8 - CELL_LOG2));
        s1_v_d     = 8'(16'(y[CELL_LOG2-1:0]) << (8 - CELL_LOG2));
        s1_g00_d   = grad_sel(ci, cj);
        s1_g10_d   = grad_sel(ci1, cj);
        s1_g01_d   = grad_sel(ci, cj1);
        s1_g11_d   = grad_sel(ci1, cj1);
    end

    // S2: corner dot products and fade curves.
    always_comb begin
        uo         = $signed(11'(s1_u_q));
        vo         = $signed(11'(s1_v_q));
        um         = uo - 11'sd256;
        vm         = vo - 11'sd256;
        s2_valid_d = s1_valid_q;
        s2_side_d  = s1_side_q;
        s2_d00_d   = dot(s1_g00_q, uo, vo);
        s2_d10_d   = dot(s1_g10_q, um, vo);
        s2_d01_d   = dot(s1_g01_q, uo, vm);
        s2_d11_d   = dot(s1_g11_q, um, vm);
        s2_su_d    = fade(s1_u_q);
        s2_sv_d    = fade(s1_v_q);
    end

    // S3: horizontal lerps.
    always_comb begin
        s3_valid_d = s2_valid_q;
        s3_side_d  = s2_side_q;
        s3_nx0_d   = lerp(12'(s2_d00_q), 12'(s2_d10_q), s2_su_q);
        s3_nx1_d   = lerp(12'(s2_d01_q), 12'(s2_d11_q), s2_su_q);
        s3_sv_d    = s2_sv_q;
    end

    // S4: vertical lerp, bias to 128 and saturate.
    always_comb begin
        out_valid_d = s3_valid_q;
        side_out_d  = s3_side_q;
        n           = lerp(s3_nx0_q, s3_nx1_q, s3_sv_q);
        nq          = n >>> 2;
        nsum        = 13'(nq) + 13'sd128;
        if (nsum < 0) begin
            noise_d = 8'h00;
        end else if (nsum > 13'sd255) begin
            noise_d = 8'hFF;
        end else begin
            noise_d = nsum[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            t_q         <= '0;
            s1_valid_q  <= 1'b0;
            s1_side_q   <= '0;
            s1_u_q      <= '0;
            s1_v_q      <= '0;
            s1_g00_q    <= '0;
            s1_g10_q    <= '0;
            s1_g01_q    <= '0;
            s1_g11_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_side_q   <= '0;
            s2_d00_q    <= '0;
            s2_d10_q    <= '0;
            s2_d01_q    <= '0;
            s2_d11_q    <= '0;
            s2_su_q     <= '0;
            s2_sv_q     <= '0;
            s3_valid_q  <= 1'b0;
            s3_side_q   <= '0;
            s3_nx0_q    <= '0;
            s3_nx1_q    <= '0;
            s3_sv_q     <= '0;
            out_valid_q <= 1'b0;
            side_out_q  <= '0;
            noise_q     <= '0;
        end else begin
            t_q         <= t_d;
            s1_valid_q  <= s1_valid_d;
            s1_side_q   <= s1_side_d;
            s1_u_q      <= s1_u_d;
            s1_v_q      <= s1_v_d;
            s1_g00_q    <= s1_g00_d;
            s1_g10_q    <= s1_g10_d;
            s1_g01_q    <= s1_g01_d;
            s1_g11_q    <= s1_g11_d;
            s2_valid_q  <= s2_valid_d;
            s2_side_q   <= s2_side_d;
            s2_d00_q    <= s2_d00_d;
            s2_d10_q    <= s2_d10_d;
            s2_d01_q    <= s2_d01_d;
            s2_d11_q    <= s2_d11_d;
            s2_su_q     <= s2_su_d;
            s2_sv_q     <= s2_sv_d;
            s3_valid_q  <= s3_valid_d;
            s3_side_q   <= s3_side_d;
            s3_nx0_q    <= s3_nx0_d;
            s3_nx1_q    <= s3_nx1_d;
            s3_sv_q     <= s3_sv_d;
            out_valid_q <= out_valid_d;
            side_out_q  <= side_out_d;
            noise_q     <= noise_d;
        end
    end

    assign noise     = noise_q;
    assign out_valid = out_valid_q;
    assign side_out  = side_out_q;

endmodule

// File: tb/tb_perlin_noise_pipe.sv
// Bench for perlin_noise_pipe: directed literal checks plus a per-cycle comparison
// against an integer reference model of the noise function and the 4-cycle sideband delay.
module tb_perlin_noise_pipe;

    localparam int CL     = 5;
    localparam int SEED_I = 'hA5;
    localparam int RING   = 4096;

    logic       clk;
    logic       reset;
    logic [9:0] x;
    logic [9:0] y;
    logic       in_valid;
    logic [2:0] side_in;
    logic       frame_start;
    logic [7:0] noise;
    logic       out_valid;
    logic [2:0] side_out;

    int nvec  = 0;
    int nfail = 0;

    perlin_noise_pipe #(
        .CELL_LOG2(5),
        .SEED     (8'hA5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .in_valid   (in_valid),
        .side_in    (side_in),
        .frame_start(frame_start),
        .noise      (noise),
        .out_valid  (out_valid),
        .side_out   (side_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic straight from the noise definition.
    function automatic int hash_g(int i, int j);
        return ((((i % 256) * 37 + (j % 256) * 113) % 256) ^ SEED_I) % 4;
    endfunction

    function automatic int dotp(int g, int dx, int dy);
        case (g)
            0:       return dx + dy;
            1:       return -dx + dy;
            2:       return dx - dy;
            default: return -dx - dy;
        endcase
    endfunction

    function automatic int fade_m(int w);
        return (w * w * (768 - 2 * w)) / 65536;
    endfunction

    function automatic int lerp_m(int a, int b, int s);
        return a + (((b - a) * s) >>> 8);
    endfunction

    function automatic int model_noise(int xi, int yi, int ti);
        int xe, i, j, u, v, d00, d10, d01, d11, su, sv, n, r;
        xe  = (xi + ti) % 1024;
        i   = (xe >> CL) % 256;
        j   = (yi >> CL) % 256;
        u   = (xe % (1 << CL)) * (256 >> CL);
        v   = (yi % (1 << CL)) * (256 >> CL);
        d00 = dotp(hash_g(i, j), u, v);
        d10 = dotp(hash_g(i + 1, j), u - 256, v);
        d01 = dotp(hash_g(i, j + 1), u, v - 256);
        d11 = dotp(hash_g(i + 1, j + 1), u - 256, v - 256);
        su  = fade_m(u);
        sv  = fade_m(v);
        n   = lerp_m(lerp_m(d00, d10, su), lerp_m(d01, d11, su), sv);
        r   = 128 + (n >>> 2);
        if (r < 0) r = 0;
        if (r > 255) r = 255;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        nvec++;
        if (act != req) begin
            nfail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Record what the DUT samples at each rising edge, and track the time offset.
    bit       r_rst [RING];
    bit       r_v   [RING];
    bit [2:0] r_side[RING];
    int       r_x   [RING];
    int       r_y   [RING];
    int       r_t   [RING];
    int       ec  = -1;
    int       t_m = 0;

    always @(posedge clk) begin
        int k;
        ec = ec + 1;
        k  = ec % RING;
        r_rst[k]  = reset;
        r_v[k]    = in_valid;
        r_side[k] = side_in;
        r_x[k]    = int'(x);
        r_y[k]    = int'(y);
        r_t[k]    = t_m;
        if (reset) t_m = 0;
        else if (frame_start) t_m = (t_m + 1) % 256;
    end

    // Output after edge e reflects the sample taken at edge e-3, unless reset hit in between.
    always @(negedge clk) begin
        bit zero;
        int s;
        if (ec >= 0) begin
            zero = 1'b0;
            for (int d = 0; d < 4; d++) begin
                if (ec - d < 0 || r_rst[(ec - d) % RING]) zero = 1'b1;
            end
            if (zero) begin
                chk("rst_out_valid", int'(out_valid), 0);
                chk("rst_side_out", int'(side_out), 0);
                if (r_rst[ec % RING]) chk("rst_noise", int'(noise), 0);
            end else begin
                s = (ec - 3) % RING;
                chk("out_valid", int'(out_valid), int'(r_v[s]));
                chk("side_out", int'(side_out), int'(r_side[s]));
                if (r_v[s]) begin
                    chk("noise_model", int'(noise), model_noise(r_x[s], r_y[s], r_t[s]));
                    if (((r_x[s] + r_t[s]) % 1024) % (1 << CL) == 0 && r_y[s] % (1 << CL) == 0)
                        chk("noise_lattice", int'(noise), 128);
                end
            end
        end
    end

    task automatic drive(input int xi, input int yi, input bit v, input bit [2:0] sd, input bit fs);
        x           = 10'(xi);
        y           = 10'(yi);
        in_valid    = v;
        side_in     = sd;
        frame_start = fs;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 1'b0, 3'b000, 1'b0);
    endtask

    task automatic check_one(input string name, input int xi, input int yi, input int lit);
        drive(xi, yi, 1'b1, 3'b010, 1'b0);
        repeat (3) idle();
        chk(name, int'(noise), lit);
        chk({name, "_valid"}, int'(out_valid), 1);
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b1;
        side_in     = 3'b111;
        x           = '0;
        y           = '0;
        frame_start = 1'b0;

        repeat (2) begin
            @(negedge clk);
            chk("reset_noise", int'(noise), 0);
            chk("reset_valid", int'(out_valid), 0);
            chk("reset_side", int'(side_out), 0);
        end
        reset = 1'b0;

        check_one("mid_edge_16_0", 16, 0, 96);
        check_one("lattice_0_0", 0, 0, 128);
        check_one("lattice_32_0", 32, 0, 128);
        check_one("lattice_64_96", 64, 96, 128);
        check_one("lattice_992_448", 992, 448, 128);

        // frame_start alongside a sample: that sample still sees t=0, the next sees t=1.
        drive(16, 0, 1'b1, 3'b100, 1'b1);
        drive(0, 0, 1'b1, 3'b001, 1'b0);
        idle();
        idle();
        chk("same_cycle_old_t", int'(noise), 96);
        idle();
        chk("same_cycle_new_t", int'(noise), 126);

        repeat (15) drive(0, 0, 1'b0, 3'b000, 1'b1);
        check_one("scroll_t16_x0", 0, 0, 96);
        check_one("scroll_wrap_x1008", 1008, 0, 128);

        for (int i = 0; i < 1024; i++) begin
            reset = (i == 500);
            drive(i, (i * 7) % 480, ($urandom_range(0, 4) != 0),
                  3'($urandom_range(0, 7)), (i % 300 == 299));
        end
        reset = 1'b0;
        repeat (6) idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
